// File: rtl/sbinit_pkg.sv
// Shared types and default constants for the SBINIT sideband init-pattern engine.
package sbinit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_BURST,
    SEND_GAP,
    DRAIN_BURST,
    DRAIN_GAP,
    DONE,
    TIMEOUT
  } sbinit_state_t;

  localparam int BURST_UI       = 64;
  localparam int GAP_UI         = 32;
  localparam int DETECT_ITER    = 2;
  localparam int EXTRA_ITER     = 4;
  localparam int TIMEOUT_CYCLES = 6400000;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sbinit_pattern_fsm_if.sv
// Sideband SBINIT pin and status bundle between the LTSM side and the pattern engine.
interface sbinit_pattern_fsm_if;
  logic enable_i;
  logic SB_clkPin_RX_i;
  logic SB_dataPin_RX_i;
  logic SB_clkPin_TX_o;
  logic SB_dataPin_TX_o;
  logic pattern_detected_o;
  logic done_o;
  logic error_o;

  modport master (
    output enable_i, SB_clkPin_RX_i, SB_dataPin_RX_i,
    input  SB_clkPin_TX_o, SB_dataPin_TX_o, pattern_detected_o, done_o, error_o
  );

  modport slave (
    input  enable_i, SB_clkPin_RX_i, SB_dataPin_RX_i,
    output SB_clkPin_TX_o, SB_dataPin_TX_o, pattern_detected_o, done_o, error_o
  );
endinterface

// File: rtl/sbinit_pattern_fsm_detector.sv
// RX matcher: counts consecutive well-formed bursts (exact length, alternating data starting at 1).
module sb_pattern_detector #(
  parameter int BURST_UI    = sbinit_pkg::BURST_UI,
  parameter int DETECT_ITER = sbinit_pkg::DETECT_ITER
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic clk_i,
  input  logic data_i,
  output logic detected
);
  import sbinit_pkg::*;

  localparam int RUN_W   = cnt_w(BURST_UI);
  localparam int MATCH_W = cnt_w(DETECT_ITER);

  logic [RUN_W-1:0]   run_reg, run_next;
  logic               bad_reg, bad_next;
  logic [MATCH_W-1:0] match_reg, match_next;
  logic               det_next;

  always_comb begin
    run_next   = run_reg;
    bad_next   = bad_reg;
    match_next = match_reg;
    det_next   = detected;
    if (clear) begin
      run_next   = '0;
      bad_next   = 1'b0;
      match_next = '0;
      det_next   = 1'b0;
    end else if (clk_i) begin
      // Run length saturates at BURST_UI; any further high cycle marks the burst too long.
      if (run_reg < RUN_W'(BURST_UI)) begin
        if (data_i != ~run_reg[0])
          bad_next = 1'b1;
        run_next = run_reg + 1'b1;
      end else begin
        bad_next = 1'b1;
      end
    end else if (run_reg != '0) begin
      run_next = '0;
      bad_next = 1'b0;
      if (!bad_reg && run_reg == RUN_W'(BURST_UI)) begin
        if (match_reg != MATCH_W'(DETECT_ITER))
          match_next = match_reg + 1'b1;
        if (match_reg >= MATCH_W'(DETECT_ITER - 1))
          det_next = 1'b1;
      end else begin
        match_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg   <= '0;
      bad_reg   <= 1'b0;
      match_reg <= '0;
      detected  <= 1'b0;
    end else begin
      run_reg   <= run_next;
      bad_reg   <= bad_next;
      match_reg <= match_next;
      detected  <= det_next;
    end
  end

endmodule

// File: rtl/sbinit_pattern_fsm.sv
// SBINIT sub-state engine: TX burst/gap pattern, drain iterations after detect, done/timeout.
// Optional timeout logic is enabled by defining SBINIT_TIMEOUT_EN.
module sbinit_pattern_fsm #(
  parameter int BURST_UI       = sbinit_pkg::BURST_UI,
  parameter int GAP_UI         = sbinit_pkg::GAP_UI,
  parameter int DETECT_ITER    = sbinit_pkg::DETECT_ITER,
`ifdef SBINIT_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = sbinit_pkg::TIMEOUT_CYCLES,
`endif
  parameter int EXTRA_ITER     = sbinit_pkg::EXTRA_ITER
) (
  input logic                 clk_800MHz,
  input logic                 reset_n,
  sbinit_pattern_fsm_if.slave sb
);
  import sbinit_pkg::*;

  localparam int UI_W   = cnt_w(((BURST_UI > GAP_UI) ? BURST_UI : GAP_UI) - 1);
  localparam int ITER_W = cnt_w(EXTRA_ITER - 1);
  localparam logic [UI_W-1:0]   BURST_LAST = UI_W'(BURST_UI - 1);
  localparam logic [UI_W-1:0]   GAP_LAST   = UI_W'(GAP_UI - 1);
  localparam logic [ITER_W-1:0] ITER_LAST  = ITER_W'(EXTRA_ITER - 1);

  sbinit_state_t     state_reg, state_next;
  logic [UI_W-1:0]   ui_reg, ui_next;
  logic [ITER_W-1:0] iter_reg, iter_next;
  logic              detected;
  logic              det_clear;
  logic              burst_next;
  logic              clk_tx_reg, data_tx_reg, done_reg;

  assign det_clear = !sb.enable_i || (state_reg == IDLE);

  sb_pattern_detector #(
    .BURST_UI    (BURST_UI),
    .DETECT_ITER (DETECT_ITER)
  ) u_detector (
    .clk      (clk_800MHz),
    .reset_n  (reset_n),
    .clear    (det_clear),
    .clk_i    (sb.SB_clkPin_RX_i),
    .data_i   (sb.SB_dataPin_RX_i),
    .detected (detected)
  );

`ifdef SBINIT_TIMEOUT_EN
  localparam int TO_W = cnt_w(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_reg, to_next;
  logic            active, to_hit, error_reg;

  assign active = (state_reg == SEND_BURST) || (state_reg == SEND_GAP) ||
                  (state_reg == DRAIN_BURST) || (state_reg == DRAIN_GAP);
  assign to_hit = (to_reg == TO_LAST);

  always_comb begin
    to_next = to_reg;
    if (!sb.enable_i || state_reg == IDLE)
      to_next = '0;
    else if (active && !to_hit)
      to_next = to_reg + 1'b1;
  end

  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      to_reg    <= '0;
      error_reg <= 1'b0;
    end else begin
      to_reg    <= to_next;
      error_reg <= (state_next == TIMEOUT);
    end
  end

  assign sb.error_o = error_reg;
`else
  assign sb.error_o = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ui_next    = ui_reg;
    iter_next  = iter_reg;
    if (!sb.enable_i) begin
      state_next = IDLE;
      ui_next    = '0;
      iter_next  = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          state_next = SEND_BURST;
          ui_next    = '0;
          iter_next  = '0;
        end
        SEND_BURST, DRAIN_BURST: begin
          if (ui_reg == BURST_LAST) begin
            ui_next = '0;
            if (state_reg == SEND_BURST) state_next = SEND_GAP;
            else                         state_next = DRAIN_GAP;
          end else begin
            ui_next = ui_reg + 1'b1;
          end
        end
        SEND_GAP: begin
          // Detect is only acted on at an iteration boundary, so no iteration is truncated.
          if (ui_reg == GAP_LAST) begin
            ui_next   = '0;
            iter_next = '0;
            if (detected) state_next = DRAIN_BURST;
            else          state_next = SEND_BURST;
          end else begin
            ui_next = ui_reg + 1'b1;
          end
        end
        DRAIN_GAP: begin
          if (ui_reg == GAP_LAST) begin
            ui_next = '0;
            if (iter_reg == ITER_LAST) begin
              state_next = DONE;
            end else begin
              state_next = DRAIN_BURST;
              iter_next  = iter_reg + 1'b1;
            end
          end else begin
            ui_next = ui_reg + 1'b1;
          end
        end
        default: ;
      endcase
`ifdef SBINIT_TIMEOUT_EN
      if (active && to_hit && state_next != DONE)
        state_next = TIMEOUT;
`endif
    end
  end

  assign burst_next = (state_next == SEND_BURST) || (state_next == DRAIN_BURST);

  always_ff @(posedge clk_800MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      ui_reg      <= '0;
      iter_reg    <= '0;
      clk_tx_reg  <= 1'b0;
      data_tx_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ui_reg      <= ui_next;
      iter_reg    <= iter_next;
      clk_tx_reg  <= burst_next;
      data_tx_reg <= burst_next & ~ui_next[0];
      done_reg    <= (state_next == DONE);
    end
  end

  assign sb.SB_clkPin_TX_o     = clk_tx_reg;
  assign sb.SB_dataPin_TX_o    = data_tx_reg;
  assign sb.pattern_detected_o = detected;
  assign sb.done_o             = done_reg;

endmodule
